// File: rtl/player_pkg.sv
// player_pkg: shared types, limits and helpers for the playback sequencer.
//   state_e      : transport state (STOP, PLAY, PAUSE)
//   *_MIN/MAX/RST: saturation limits and reset values for speed, volume, octave
//   sat_step()   : one saturating up/down step of a 3-bit setting
package player_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [2:0] SPEED_MIN = 3'd0;
  localparam logic [2:0] SPEED_MAX = 3'd4;
  localparam logic [2:0] SPEED_RST = 3'd2;
  localparam logic [2:0] VOL_MIN   = 3'd1;
  localparam logic [2:0] VOL_MAX   = 3'd5;
  localparam logic [2:0] VOL_RST   = 3'd3;
  localparam logic [2:0] OCT_MIN   = 3'd1;
  localparam logic [2:0] OCT_MAX   = 3'd3;
  localparam logic [2:0] OCT_RST   = 3'd2;

  // Up and down together cancel; a step past a limit is dropped.
  function automatic logic [2:0] sat_step(input logic [2:0] cur, input logic up,
                                          input logic dn, input logic [2:0] lo,
                                          input logic [2:0] hi);
    logic [2:0] nxt;
    nxt = cur;
    if (up && !dn && (cur != hi)) begin
      nxt = cur + 3'd1;
    end else if (dn && !up && (cur != lo)) begin
      nxt = cur - 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/playback_sequencer_if.sv
// playback_sequencer_if: button pulses in, sequencing status out.
//   Pulses : play_1p, stop_1p, speedup_1p, speeddown_1p, volup_1p, voldown_1p,
//            octup_1p, octdown_1p (one-cycle), loop (level)
//   Status : ibeat[11:0], beat_tick, playing, mute, speed, volume, octave
//   master : the button/debounce side; slave : the sequencer.
interface playback_sequencer_if;

  logic        play_1p;
  logic        stop_1p;
  logic        speedup_1p;
  logic        speeddown_1p;
  logic        volup_1p;
  logic        voldown_1p;
  logic        octup_1p;
  logic        octdown_1p;
  logic        loop;
  logic [11:0] ibeat;
  logic        beat_tick;
  logic        playing;
  logic        mute;
  logic [2:0]  speed;
  logic [2:0]  volume;
  logic [2:0]  octave;

  modport master (
    output play_1p, stop_1p, speedup_1p, speeddown_1p,
    output volup_1p, voldown_1p, octup_1p, octdown_1p, loop,
    input  ibeat, beat_tick, playing, mute, speed, volume, octave
  );

  modport slave (
    input  play_1p, stop_1p, speedup_1p, speeddown_1p,
    input  volup_1p, voldown_1p, octup_1p, octdown_1p, loop,
    output ibeat, beat_tick, playing, mute, speed, volume, octave
  );

endinterface

// File: rtl/playback_sequencer_tempo_divider.sv
// tempo_divider: beat-period counter.
//   clk, rst     : clock, synchronous active-high reset
//   i_speed      : tempo level 0..4; period = (BEAT_DIV<<2)>>speed
//   i_run        : count enable (PLAY only)
//   i_clear      : force the count to zero (speed change, stop, start)
//   o_beat_tick  : high in the last cycle of a beat
module tempo_divider #(
  parameter int unsigned BEAT_DIV = 4194304,
  parameter int unsigned DIV_W    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_speed,
  input  logic       i_run,
  input  logic       i_clear,
  output logic       o_beat_tick
);

  localparam logic [DIV_W-1:0] BasePeriod = DIV_W'(BEAT_DIV) << 2;

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] w_count_nxt;
  logic [DIV_W-1:0] w_last;
  logic             w_at_last;

  assign w_last    = (BasePeriod >> i_speed) - DIV_W'(1);
  assign w_at_last = (r_count == w_last);

  // A clear on the terminal cycle suppresses the tick so the beat does not advance.
  assign o_beat_tick = i_run && w_at_last && !i_clear;

  always_comb begin
    w_count_nxt = r_count;
    if (i_clear) begin
      w_count_nxt = '0;
    end else if (i_run) begin
      w_count_nxt = w_at_last ? '0 : r_count + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/playback_sequencer.sv
// playback_sequencer: play/stop/pause FSM, beat index, tempo and level settings.
//   clk, rst : clock, synchronous active-high reset
//   io_bus   : slave side of playback_sequencer_if (button pulses in,
//              ibeat/beat_tick/playing/mute/speed/volume/octave out)
module playback_sequencer
  import player_pkg::*;
#(
  parameter int unsigned LEN      = 64,
  parameter int unsigned BEAT_DIV = 4194304,
  parameter int unsigned DIV_W    = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  playback_sequencer_if.slave  io_bus
);

  localparam logic [11:0] LastBeat = 12'(LEN - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [11:0] r_ibeat;
  logic [11:0] w_ibeat_nxt;
  logic [2:0]  r_speed;
  logic [2:0]  r_volume;
  logic [2:0]  r_octave;
  logic [2:0]  w_speed_nxt;
  logic [2:0]  w_volume_nxt;
  logic [2:0]  w_octave_nxt;
  logic        w_speed_chg;
  logic        w_run;
  logic        w_clear;
  logic        w_tick;

  assign w_speed_nxt  = sat_step(r_speed, io_bus.speedup_1p, io_bus.speeddown_1p,
                                 SPEED_MIN, SPEED_MAX);
  assign w_volume_nxt = sat_step(r_volume, io_bus.volup_1p, io_bus.voldown_1p,
                                 VOL_MIN, VOL_MAX);
  assign w_octave_nxt = sat_step(r_octave, io_bus.octup_1p, io_bus.octdown_1p,
                                 OCT_MIN, OCT_MAX);
  assign w_speed_chg  = (w_speed_nxt != r_speed);

  assign w_run   = (r_state == PLAY);
  // Starting from STOP also clears, though the count is already zero there.
  assign w_clear = w_speed_chg || io_bus.stop_1p ||
                   ((r_state == STOP) && io_bus.play_1p);

  tempo_divider #(
    .BEAT_DIV (BEAT_DIV),
    .DIV_W    (DIV_W)
  ) u_tempo_divider (
    .clk         (clk),
    .rst         (rst),
    .i_speed     (r_speed),
    .i_run       (w_run),
    .i_clear     (w_clear),
    .o_beat_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ibeat_nxt = r_ibeat;
    if (io_bus.stop_1p) begin
      w_state_nxt = STOP;
      w_ibeat_nxt = '0;
    end else begin
      unique case (r_state)
        STOP: begin
          if (io_bus.play_1p) begin
            w_state_nxt = PLAY;
            w_ibeat_nxt = '0;
          end
        end
        PLAY: begin
          if (io_bus.play_1p) begin
            w_state_nxt = PAUSE;
          end
          if (w_tick) begin
            if (r_ibeat == LastBeat) begin
              w_ibeat_nxt = '0;
              // End of song without loop overrides a same-cycle pause.
              if (!io_bus.loop) begin
                w_state_nxt = STOP;
              end
            end else begin
              w_ibeat_nxt = r_ibeat + 12'd1;
            end
          end
        end
        PAUSE: begin
          if (io_bus.play_1p) begin
            w_state_nxt = PLAY;
          end
        end
        default: begin
          w_state_nxt = STOP;
          w_ibeat_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= STOP;
      r_ibeat  <= '0;
      r_speed  <= SPEED_RST;
      r_volume <= VOL_RST;
      r_octave <= OCT_RST;
    end else begin
      r_state  <= w_state_nxt;
      r_ibeat  <= w_ibeat_nxt;
      r_speed  <= w_speed_nxt;
      r_volume <= w_volume_nxt;
      r_octave <= w_octave_nxt;
    end
  end

  assign io_bus.ibeat     = r_ibeat;
  assign io_bus.beat_tick = w_tick;
  assign io_bus.playing   = (r_state == PLAY);
  assign io_bus.mute      = (r_state != PLAY);
  assign io_bus.speed     = r_speed;
  assign io_bus.volume    = r_volume;
  assign io_bus.octave    = r_octave;

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: directed scenarios followed by random button
// traffic, every cycle compared against a cycle-level behavioural model.
module tb_playback_sequencer;

  localparam int unsigned LEN      = 4;
  localparam int unsigned BEAT_DIV = 4;
  localparam int unsigned DIV_W    = 25;

  localparam logic [8:0] K_PLAY = 9'h001;
  localparam logic [8:0] K_STOP = 9'h002;
  localparam logic [8:0] K_SU   = 9'h004;
  localparam logic [8:0] K_SD   = 9'h008;
  localparam logic [8:0] K_VU   = 9'h010;
  localparam logic [8:0] K_VD   = 9'h020;
  localparam logic [8:0] K_OU   = 9'h040;
  localparam logic [8:0] K_OD   = 9'h080;
  localparam logic [8:0] K_RST  = 9'h100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  playback_sequencer_if u_if ();

  playback_sequencer #(
    .LEN      (LEN),
    .BEAT_DIV (BEAT_DIV),
    .DIV_W    (DIV_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (u_if)
  );

  int checks = 0;
  int errors = 0;

  // Model: state 0=stopped 1=playing 2=paused; phase = cycles elapsed in beat.
  int m_state, m_phase, m_beat, m_speed, m_vol, m_oct;

  function automatic int sat(int cur, bit up, bit dn, int lo, int hi);
    if (up && !dn && cur < hi) return cur + 1;
    if (dn && !up && cur > lo) return cur - 1;
    return cur;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_phase = 0;
    m_beat  = 0;
    m_speed = 2;
    m_vol   = 3;
    m_oct   = 2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [8:0] k);
    int  period, ns;
    bit  spd_chg, exp_tick, ended;
    u_if.play_1p      = k[0];
    u_if.stop_1p      = k[1];
    u_if.speedup_1p   = k[2];
    u_if.speeddown_1p = k[3];
    u_if.volup_1p     = k[4];
    u_if.voldown_1p   = k[5];
    u_if.octup_1p     = k[6];
    u_if.octdown_1p   = k[7];
    rst               = k[8];
    @(negedge clk);
    period   = (BEAT_DIV * 4) / (1 << m_speed);
    ns       = sat(m_speed, k[2], k[3], 0, 4);
    spd_chg  = (ns != m_speed);
    exp_tick = (m_state == 1) && (m_phase == period - 1) && !k[1] && !spd_chg;
    chk("beat_tick", 32'(u_if.beat_tick), 32'(exp_tick));
    chk("ibeat",     32'(u_if.ibeat),     32'(m_beat));
    chk("playing",   32'(u_if.playing),   32'(m_state == 1));
    chk("mute",      32'(u_if.mute),      32'(m_state != 1));
    chk("speed",     32'(u_if.speed),     32'(m_speed));
    chk("volume",    32'(u_if.volume),    32'(m_vol));
    chk("octave",    32'(u_if.octave),    32'(m_oct));
    if (k[8]) begin
      model_reset();
    end else begin
      ended   = 1'b0;
      m_speed = ns;
      m_vol   = sat(m_vol, k[4], k[5], 1, 5);
      m_oct   = sat(m_oct, k[6], k[7], 1, 3);
      case (m_state)
        0: begin
          if (k[0]) begin
            m_state = 1;
            m_beat  = 0;
            m_phase = 0;
          end
        end
        1: begin
          if (exp_tick) begin
            m_phase = 0;
            if (m_beat == LEN - 1) begin
              m_beat = 0;
              ended  = !u_if.loop;
            end else begin
              m_beat++;
            end
          end else if (spd_chg) begin
            m_phase = 0;
          end else begin
            m_phase++;
          end
          if (ended) m_state = 0;
          else if (k[0]) m_state = 2;
        end
        default: begin
          if (spd_chg) m_phase = 0;
          if (k[0]) m_state = 1;
        end
      endcase
      if (k[1]) begin
        m_state = 0;
        m_beat  = 0;
        m_phase = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(9'h000);
  endtask

  initial begin
    logic [8:0] k;
    u_if.play_1p      = 1'b0;
    u_if.stop_1p      = 1'b0;
    u_if.speedup_1p   = 1'b0;
    u_if.speeddown_1p = 1'b0;
    u_if.volup_1p     = 1'b0;
    u_if.voldown_1p   = 1'b0;
    u_if.octup_1p     = 1'b0;
    u_if.octdown_1p   = 1'b0;
    u_if.loop         = 1'b1;
    rst               = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_ibeat",  32'(u_if.ibeat),   32'd0);
    chk("rst_speed",  32'(u_if.speed),   32'd2);
    chk("rst_volume", 32'(u_if.volume),  32'd3);
    chk("rst_octave", 32'(u_if.octave),  32'd2);
    chk("rst_mute",   32'(u_if.mute),    32'd1);

    // 1: looping playback
    cyc(K_PLAY);
    chk("s1_playing", 32'(u_if.playing), 32'd1);
    idle(18);

    // 2: no loop, song ends and stops
    u_if.loop = 1'b0;
    cyc(K_STOP);
    cyc(K_PLAY);
    idle(20);
    chk("s2_mute",  32'(u_if.mute),  32'd1);
    chk("s2_ibeat", 32'(u_if.ibeat), 32'd0);

    // 3: pause two cycles into beat 1, then resume
    u_if.loop = 1'b1;
    cyc(K_PLAY);
    idle(5);
    cyc(K_PLAY);
    idle(20);
    chk("s3_ibeat_held", 32'(u_if.ibeat), 32'd1);
    cyc(K_PLAY);
    idle(6);

    // 4: speed saturation and period change
    for (int i = 0; i < 3; i++) begin
      cyc(K_SU);
      idle(4);
    end
    chk("s4_speed_max", 32'(u_if.speed), 32'd4);
    for (int i = 0; i < 5; i++) begin
      cyc(K_SD);
      idle(2);
    end
    chk("s4_speed_min", 32'(u_if.speed), 32'd0);
    idle(34);

    // 5: volume/octave saturation and cancelling pair
    for (int i = 0; i < 4; i++) cyc(K_VU);
    chk("s5_volume", 32'(u_if.volume), 32'd5);
    cyc(K_OD);
    cyc(K_OD);
    chk("s5_octave", 32'(u_if.octave), 32'd1);
    cyc(K_VU | K_VD);
    chk("s5_vol_pair", 32'(u_if.volume), 32'd5);
    cyc(K_OU | K_OD);

    // 6: stop beats play; reset during pause
    cyc(K_SU);
    cyc(K_SU);
    cyc(K_STOP);
    cyc(K_PLAY);
    idle(8);
    cyc(K_PLAY | K_STOP);
    chk("s6_stopped", 32'(u_if.playing), 32'd0);
    chk("s6_ibeat",   32'(u_if.ibeat),   32'd0);
    cyc(K_PLAY);
    idle(2);
    cyc(K_PLAY);
    idle(3);
    cyc(K_RST | K_PLAY | K_VU);
    chk("s6_rst_mute",  32'(u_if.mute),   32'd1);
    chk("s6_rst_speed", 32'(u_if.speed),  32'd2);
    chk("s6_rst_vol",   32'(u_if.volume), 32'd3);
    chk("s6_rst_oct",   32'(u_if.octave), 32'd2);

    // Random button traffic
    for (int n = 0; n < 800; n++) begin
      k = 9'h000;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(15) == 0) k[b] = 1'b1;
      end
      if ($urandom_range(199) == 0) k[8] = 1'b1;
      if ($urandom_range(63) == 0) u_if.loop = ~u_if.loop;
      cyc(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
